// File: rtl/mandel_row_scheduler_pkg.sv
// Shared types and register-map constants for the Mandelbrot row scheduler.
// Imported by the scheduler top and its round-robin picker.
package mandel_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } sched_state_e;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_NUM_ROWS = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_CYCLES   = 2'd3;

    localparam int START_BIT = 0;
    localparam int ABORT_BIT = 1;

    localparam int BUSY_BIT       = 0;
    localparam int DONE_BIT       = 1;
    localparam int ABORT_FLAG_BIT = 2;
    localparam int ROWS_LSB       = 16;

    function automatic logic state_is_busy(input sched_state_e st);
        return (st == ST_DISPATCH) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/mandel_row_scheduler_if.sv
// Avalon-MM register bus between the HPS bridge (master) and the row scheduler (slave).
interface mandel_row_scheduler_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/mandel_row_scheduler_rr_idle_picker.sv
// Combinational round-robin picker: grants the first requesting solver at or after ptr,
// wrapping modulo NUM_SOLVERS. Grant is one-hot; valid is low when nothing requests.
module rr_idle_picker
    import mandel_sched_pkg::*;
#(
    parameter int NUM_SOLVERS = 4,
    parameter int PTR_W       = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1
) (
    input  logic [NUM_SOLVERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_SOLVERS-1:0] grant,
    output logic                   valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            if (!valid && req[(int'(ptr) + k) % NUM_SOLVERS]) begin
                grant[(int'(ptr) + k) % NUM_SOLVERS] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mandel_row_scheduler.sv
// Avalon-MM row-work dispatcher shared by NUM_SOLVERS Mandelbrot engines.
// Optional busy-cycle counter at the CYCLES register is enabled by MANDEL_SCHED_CYCLE_CNT_EN.
module mandel_row_scheduler
    import mandel_sched_pkg::*;
#(
    parameter int NUM_SOLVERS  = 4,
    parameter int ROW_W        = 10,
    parameter int NUM_ROWS_RST = 480
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mandel_row_scheduler_if.slave  bus,
    output logic [NUM_SOLVERS-1:0] solver_start,
    output logic [ROW_W-1:0]       solver_row,
    input  logic [NUM_SOLVERS-1:0] solver_busy,
    input  logic [NUM_SOLVERS-1:0] solver_done
);

    localparam int PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    sched_state_e            state_q, state_d;
    logic [ROW_W-1:0]        num_rows_q, num_rows_d;
    logic [ROW_W-1:0]        next_row_q, next_row_d;
    logic [ROW_W-1:0]        rows_done_q, rows_done_d;
    logic [NUM_SOLVERS-1:0]  outstanding_q, outstanding_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_SOLVERS-1:0]  solver_start_q, solver_start_d;
    logic [ROW_W-1:0]        solver_row_q, solver_row_d;

    logic                    bus_write;
    logic                    ctrl_write;
    logic                    start_cmd;
    logic                    abort_cmd;
    logic                    busy;
    logic                    start_accept;
    logic [NUM_SOLVERS-1:0]  eligible;
    logic [NUM_SOLVERS-1:0]  grant;
    logic                    grant_valid;
    logic [PTR_W-1:0]        grant_idx;
    logic [NUM_SOLVERS-1:0]  issue_mask;
    logic [NUM_SOLVERS-1:0]  done_hits;
    logic [ROW_W-1:0]        done_cnt;

    assign bus_write  = bus.chipselect & ~bus.write_n;
    assign ctrl_write = bus_write && (bus.address == ADDR_CTRL);
    assign abort_cmd  = ctrl_write & bus.writedata[ABORT_BIT];
    assign start_cmd  = ctrl_write & bus.writedata[START_BIT] & ~bus.writedata[ABORT_BIT];
    assign busy       = state_is_busy(state_q);
    assign start_accept = start_cmd && !busy;

    // Outstanding solvers are excluded even if they have not yet raised busy.
    assign eligible  = ~solver_busy & ~outstanding_q;
    assign done_hits = solver_done & outstanding_q;

    rr_idle_picker #(
        .NUM_SOLVERS (NUM_SOLVERS),
        .PTR_W       (PTR_W)
    ) u_picker (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            done_cnt = done_cnt + ROW_W'(done_hits[i]);
        end
    end

    always_comb begin
        state_d        = state_q;
        num_rows_d     = num_rows_q;
        next_row_d     = next_row_q;
        rows_done_d    = rows_done_q;
        done_d         = done_q;
        aborted_d      = aborted_q;
        rr_ptr_d       = rr_ptr_q;
        solver_start_d = '0;
        solver_row_d   = solver_row_q;
        issue_mask     = '0;

        if (bus_write && (bus.address == ADDR_NUM_ROWS) && !busy) begin
            num_rows_d = bus.writedata[ROW_W-1:0];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_cmd) begin
                    next_row_d  = '0;
                    rows_done_d = '0;
                    aborted_d   = 1'b0;
                    if (num_rows_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DISPATCH;
                        done_d  = 1'b0;
                    end
                end
            end
            ST_DISPATCH: begin
                if (abort_cmd) begin
                    state_d   = ST_DRAIN;
                    aborted_d = 1'b1;
                end else if (grant_valid) begin
                    issue_mask     = grant;
                    solver_start_d = grant;
                    solver_row_d   = next_row_q;
                    next_row_d     = next_row_q + ROW_W'(1);
                    rr_ptr_d       = (grant_idx == PTR_W'(NUM_SOLVERS - 1)) ? '0
                                                                             : grant_idx + PTR_W'(1);
                    if (next_row_q == num_rows_q - ROW_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_cmd) begin
                    aborted_d = 1'b1;
                end
                if (outstanding_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completions are accounted independently of the FSM so draining rows still count.
        outstanding_d = (outstanding_q & ~solver_done) | issue_mask;
        rows_done_d   = rows_done_d + done_cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            num_rows_q     <= ROW_W'(NUM_ROWS_RST);
            next_row_q     <= '0;
            rows_done_q    <= '0;
            outstanding_q  <= '0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            rr_ptr_q       <= '0;
            solver_start_q <= '0;
            solver_row_q   <= '0;
        end else begin
            state_q        <= state_d;
            num_rows_q     <= num_rows_d;
            next_row_q     <= next_row_d;
            rows_done_q    <= rows_done_d;
            outstanding_q  <= outstanding_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
            rr_ptr_q       <= rr_ptr_d;
            solver_start_q <= solver_start_d;
            solver_row_q   <= solver_row_d;
        end
    end

    assign solver_start = solver_start_q;
    assign solver_row   = solver_row_q;

`ifdef MANDEL_SCHED_CYCLE_CNT_EN
    logic [31:0] cycles_q, cycles_d;

    // Counts cycles spent in DISPATCH/DRAIN; holds once DONE and saturates at all-ones.
    always_comb begin
        cycles_d = cycles_q;
        if (start_accept) begin
            cycles_d = '0;
        end else if (busy && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end
`else
    logic [31:0] cycles_q;
    assign cycles_q = 32'd0;
`endif

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                bus.readdata = '0;
            end
            ADDR_NUM_ROWS: begin
                bus.readdata = 32'(num_rows_q);
            end
            ADDR_STATUS: begin
                bus.readdata[BUSY_BIT]             = busy;
                bus.readdata[DONE_BIT]             = done_q;
                bus.readdata[ABORT_FLAG_BIT]       = aborted_q;
                bus.readdata[ROWS_LSB +: ROW_W]    = rows_done_q;
            end
            ADDR_CYCLES: begin
                bus.readdata = cycles_q;
            end
            default: begin
                bus.readdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mandel_row_scheduler.sv
// Scoreboard testbench for mandel_row_scheduler; checks CYCLES when MANDEL_SCHED_CYCLE_CNT_EN is defined.
module tb_mandel_row_scheduler;
    import mandel_sched_pkg::*;

    localparam int NS = 4;
    localparam int RW = 10;

    typedef struct {
        int solver;
        int row;
    } issue_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NS-1:0] solver_start;
    logic [RW-1:0] solver_row;
    logic [NS-1:0] solver_busy;
    logic [NS-1:0] solver_done = '0;
    logic [NS-1:0] sim_busy = '0;
    logic [NS-1:0] busy_force = '0;

    issue_t expQ[$];
    int     total = 0;
    int     bad = 0;
    int     cycleNum = 0;

    mandel_row_scheduler_if bus();

    assign solver_busy = sim_busy | busy_force;

    mandel_row_scheduler #(
        .NUM_SOLVERS  (NS),
        .ROW_W        (RW),
        .NUM_ROWS_RST (480)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .solver_start (solver_start),
        .solver_row   (solver_row),
        .solver_busy  (solver_busy),
        .solver_done  (solver_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Solver model: starts make a solver busy until its done pulse; every start is scoreboarded.
    always @(negedge clk) begin : solverModel
        issue_t e;
        if (!reset_n) begin
            sim_busy <= '0;
        end else begin
            if (solver_start != '0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_start", 32'(solver_start), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("start_vec_row%0d", e.row), 32'(solver_start), 32'(1 << e.solver));
                    checkOutput($sformatf("start_row_row%0d", e.row), 32'(solver_row), 32'(e.row));
                end
            end
            sim_busy <= (sim_busy | solver_start) & ~solver_done;
        end
    end

    task automatic expectIssue(input int solver, input int row);
        issue_t e;
        e.solver = solver;
        e.row    = row;
        expQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = data;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        data           = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic pulseDone(input logic [NS-1:0] mask);
        @(posedge clk);
        #1;
        solver_done = mask;
        @(posedge clk);
        #1;
        solver_done = '0;
    endtask

    task automatic waitDone(input string tag, input int bound, output int doneEdge);
        logic [31:0] st;
        doneEdge = -1;
        st = '0;
        for (int i = 0; i < bound; i++) begin
            readReg(ADDR_STATUS, st);
            if (st[DONE_BIT]) begin
                doneEdge = cycleNum;
                break;
            end
            tick(1);
        end
        checkOutput(tag, 32'(st[DONE_BIT]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          tStart;
        int          tDone;

        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #23;
        reset_n = 1'b1;
        tick(1);

        $display("[TB] reset values");
        readReg(ADDR_NUM_ROWS, rd);
        checkOutput("rst_num_rows", rd, 32'd480);
        readReg(ADDR_STATUS, rd);
        checkOutput("rst_status", rd, 32'd0);
        readReg(ADDR_CTRL, rd);
        checkOutput("rst_ctrl", rd, 32'd0);
        tick(3);
        checkOutput("rst_start", 32'(solver_start), 32'd0);
`ifdef MANDEL_SCHED_CYCLE_CNT_EN
        readReg(ADDR_CYCLES, rd);
        checkOutput("rst_cycles", rd, 32'd0);
`endif

        $display("[TB] six rows over four solvers");
        applyStimulus(ADDR_NUM_ROWS, 32'd6);
        readReg(ADDR_NUM_ROWS, rd);
        checkOutput("t2_num_rows", rd, 32'd6);
        for (int i = 0; i < 4; i++) expectIssue(i, i);
        applyStimulus(ADDR_CTRL, 32'h1);
        tStart = cycleNum;
        checkOutput("t2_latency_t1", 32'(solver_start), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("t2_issue%0d", i), 32'(solver_start), 32'(1 << i));
        end
        tick(2);
        checkOutput("t2_no_eligible", 32'(solver_start), 32'd0);
        expectIssue(1, 4);
        pulseDone(4'b0010);
        tick(2);
        expectIssue(0, 5);
        pulseDone(4'b0001);
        tick(2);
        readReg(ADDR_STATUS, rd);
        checkOutput("t2_drain_status", rd, 32'h0002_0001);
        applyStimulus(ADDR_NUM_ROWS, 32'd99);
        readReg(ADDR_NUM_ROWS, rd);
        checkOutput("t6_num_rows_locked", rd, 32'd6);
        applyStimulus(ADDR_CTRL, 32'h1);
        readReg(ADDR_STATUS, rd);
        checkOutput("t2_start_ignored", rd, 32'h0002_0001);
        pulseDone(4'b1101);
        readReg(ADDR_STATUS, rd);
        checkOutput("t2_multi_done", rd, 32'h0005_0001);
        pulseDone(4'b0010);
        waitDone("t2_done_seen", 5, tDone);
        readReg(ADDR_STATUS, rd);
        checkOutput("t2_final_status", rd, 32'h0006_0002);
        checkOutput("t2_queue_empty", 32'(expQ.size()), 32'd0);
`ifdef MANDEL_SCHED_CYCLE_CNT_EN
        readReg(ADDR_CYCLES, rd);
        checkOutput("t6_cycles", rd, 32'(tDone - tStart));
        tick(3);
        readReg(ADDR_CYCLES, rd);
        checkOutput("t6_cycles_frozen", rd, 32'(tDone - tStart));
`endif

        $display("[TB] zero rows");
        applyStimulus(ADDR_NUM_ROWS, 32'd0);
        readReg(ADDR_NUM_ROWS, rd);
        checkOutput("t3_num_rows", rd, 32'd0);
        applyStimulus(ADDR_CTRL, 32'h1);
        tStart = cycleNum;
        waitDone("t3_done_seen", 2, tDone);
        readReg(ADDR_STATUS, rd);
        checkOutput("t3_status", rd, 32'h0000_0002);
        tick(3);
        checkOutput("t3_queue_empty", 32'(expQ.size()), 32'd0);
`ifdef MANDEL_SCHED_CYCLE_CNT_EN
        readReg(ADDR_CYCLES, rd);
        checkOutput("t3_cycles", rd, 32'(tDone - tStart));
`endif

        $display("[TB] abort after two issues");
        busy_force = 4'b1100;
        applyStimulus(ADDR_NUM_ROWS, 32'd10);
        expectIssue(1, 0);
        expectIssue(0, 1);
        applyStimulus(ADDR_CTRL, 32'h1);
        tStart = cycleNum;
        tick(4);
        checkOutput("t4_stalled", 32'(solver_start), 32'd0);
        applyStimulus(ADDR_CTRL, 32'h3);
        busy_force = '0;
        tick(3);
        readReg(ADDR_STATUS, rd);
        checkOutput("t4_aborting", rd, 32'h0000_0005);
        pulseDone(4'b0001);
        readReg(ADDR_STATUS, rd);
        checkOutput("t4_busy_hold", rd, 32'h0001_0005);
        pulseDone(4'b0010);
        waitDone("t4_done_seen", 5, tDone);
        readReg(ADDR_STATUS, rd);
        checkOutput("t4_final_status", rd, 32'h0002_0006);
        checkOutput("t4_queue_empty", 32'(expQ.size()), 32'd0);
`ifdef MANDEL_SCHED_CYCLE_CNT_EN
        readReg(ADDR_CYCLES, rd);
        checkOutput("t4_cycles", rd, 32'(tDone - tStart));
`endif

        $display("[TB] simultaneous and spurious dones");
        busy_force = 4'b1000;
        applyStimulus(ADDR_NUM_ROWS, 32'd3);
        expectIssue(1, 0);
        expectIssue(2, 1);
        expectIssue(0, 2);
        applyStimulus(ADDR_CTRL, 32'h1);
        tick(5);
        readReg(ADDR_STATUS, rd);
        checkOutput("t5_all_issued", rd, 32'h0000_0001);
        pulseDone(4'b1101);
        readReg(ADDR_STATUS, rd);
        checkOutput("t5_rows_plus2", rd, 32'h0002_0001);
        busy_force = '0;
        pulseDone(4'b0010);
        waitDone("t5_done_seen", 5, tDone);
        readReg(ADDR_STATUS, rd);
        checkOutput("t5_final_status", rd, 32'h0003_0002);
        checkOutput("t5_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] reset mid-run");
        applyStimulus(ADDR_NUM_ROWS, 32'd20);
        expectIssue(1, 0);
        applyStimulus(ADDR_CTRL, 32'h1);
        @(posedge clk);
        #6;
        reset_n = 1'b0;
        #1;
        checkOutput("t7_start_cleared", 32'(solver_start), 32'd0);
        readReg(ADDR_NUM_ROWS, rd);
        checkOutput("t7_num_rows_rst", rd, 32'd480);
        readReg(ADDR_STATUS, rd);
        checkOutput("t7_status_rst", rd, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);
        checkOutput("t7_idle_after_rst", 32'(solver_start), 32'd0);
        readReg(ADDR_STATUS, rd);
        checkOutput("t7_status_idle", rd, 32'd0);
        checkOutput("t7_queue_empty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
